bus_grant_arbiter: RTL

- Round-robin arbiter that generates the per-source select lines (sa, sb, ...) for the NAND selection-mux trees that drive the shared 8-bit internal bus.
- Selects at most one source per cycle, and "no source" is a legal output.
- Guarantees a one-cycle all-zero select gap between owners, so a downstream selection mux never sees two selects high and never ORs two sources onto the bus.
- Sits directly upstream of the bus selection-mux stage.

---
 rtl/bus_grant_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_grant_arbiter
// Description : Round-robin select generator for the shared 8-bit bus muxes,
//               with a one-cycle all-zero gap between owners.
// Revision    : 1.0
// ============================================================================
module bus_grant_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             bus_busy,
  output logic             expired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N - 1);
  localparam logic [N-1:0]     C_ONE      = N'(1);

  generate
    if ((N < 2) || (N > 8) || (IDX_W != $clog2(N)) || (CNT_W < 1) ||
        (MAX_HOLD < 0) || (MAX_HOLD >= (1 << CNT_W))) begin : g_bad_params
      $error("bus_grant_arbiter: illegal parameter combination");
    end
  endgenerate

  state_t           r_state;
  logic [N-1:0]     r_grant;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_expired;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nx;
  logic [N-1:0]     w_grant_nx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             w_exp_nx;
  logic [IDX_W-1:0] w_ptr_nx;
  logic [CNT_W-1:0] w_cnt_nx;

  logic             w_pick_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_owner_req;
  logic             w_limit;

  // First requester found scanning upward from r_ptr, wrapping modulo N.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand       = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % N);
      if (!w_pick_found && req[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  assign w_owner_req = req[r_idx];
  assign w_limit     = (MAX_HOLD != 0) && (r_cnt == C_MAX_HOLD);

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = '0;
    w_idx_nx   = '0;
    w_exp_nx   = 1'b0;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_OWN: begin
        if (!w_owner_req || w_limit) begin
          // Expiry is only flagged when the owner still wanted the bus.
          w_state_nx = S_GAP;
          w_exp_nx   = w_owner_req;
          w_ptr_nx   = (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_grant_nx = r_grant;
          w_idx_nx   = r_idx;
          if (r_cnt != C_CNT_SAT) begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        if (w_pick_found) begin
          w_state_nx = S_OWN;
          w_grant_nx = C_ONE << w_pick_idx;
          w_idx_nx   = w_pick_idx;
          w_cnt_nx   = C_CNT_ONE;
        end else begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_idx     <= w_idx_nx;
      r_busy    <= |w_grant_nx;
      r_expired <= w_exp_nx;
      r_ptr     <= w_ptr_nx;
      r_cnt     <= w_cnt_nx;
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_idx;
  assign bus_busy  = r_busy;
  assign expired   = r_expired;

endmodule
`default_nettype wire
